// File: rtl/vga_buffer_reader_pkg.sv
// Shared VGA timing constants and types for the frame-buffer reader and the
// capture side that fills the same buffer.
package vga_buffer_reader_pkg;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_FRAME_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;
  localparam int VGA_RD_LAT       = 1;

  localparam int FB_ADDR_W = 19;
  localparam int CNT_W     = 10;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [11:0]          rgb_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  // Per-pixel control flags that travel alongside the data path
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic origin;
  } vga_sync_t;

  localparam vga_sync_t SYNC_BLANK = '{hsync_n: 1'b1, vsync_n: 1'b1, origin: 1'b0};

endpackage

// File: rtl/vga_buffer_reader_if.sv
// Frame-buffer read port: address and read strobe out, pixel data back.
interface vga_buffer_reader_if;
  import vga_buffer_reader_pkg::*;

  fb_addr_t buff_addr;
  logic     buff_rd;
  rgb_t     buff_din;

  modport master (output buff_addr, output buff_rd, input buff_din);
  modport slave  (input buff_addr, input buff_rd, output buff_din);
endinterface

// File: rtl/vga_buffer_reader_timing_gen.sv
// Raster counters and the raw (undelayed) sync, active and frame-origin flags.
module vga_timing_gen
  import vga_buffer_reader_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic      pclk,
  input  logic      rst,
  output vga_sync_t sync_o,
  output logic      active_o,
  output logic      v_blank_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C   = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SYNC_LO = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_HI = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SYNC_LO = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_HI = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Next raster position; line and frame wrap land on the same edge
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    h_cnt_d = h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  // Counter registers
  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o       = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign v_blank_o      = (v_cnt_q >= V_ACT_C);
  assign sync_o.hsync_n = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI));
  assign sync_o.vsync_n = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI));
  assign sync_o.origin  = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_buffer_reader.sv
// Reads the frame buffer in raster order and drives the VGA pins, with sync,
// blanking and frame_start aligned to the buffer read latency.
module vga_buffer_reader
  import vga_buffer_reader_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int RD_LAT   = VGA_RD_LAT
) (
  input  logic                pclk,
  input  logic                rst,
  vga_buffer_reader_if.master fb,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                frame_start
);

  // Counters-to-pins latency: address stage, RD_LAT of buffer, output stage
  localparam int DEPTH = RD_LAT + 2;

  vga_sync_t sync_raw;
  logic      active_raw;
  logic      v_blank_raw;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .pclk      (pclk),
    .rst       (rst),
    .sync_o    (sync_raw),
    .active_o  (active_raw),
    .v_blank_o (v_blank_raw)
  );

  fb_addr_t        addr_q, addr_d;
  fb_addr_t        next_q, next_d;      // address of the next active pixel
  logic [RD_LAT:0] act_dly_q;           // bit 0 doubles as the read strobe
  vga_sync_t       sync_dly_q [DEPTH];
  rgb_t            rgb_q;

  // Address generation: advance on active pixels, hold in blanking, rewind in vertical blanking
  always_comb begin
    addr_d = addr_q;
    next_d = next_q;
    if (v_blank_raw) begin
      addr_d = '0;
      next_d = '0;
    end else if (active_raw) begin
      addr_d = next_q;
      next_d = next_q + fb_addr_t'(1);
    end
  end

  // Stage 1 registers and the active-flag delay that gates the pixel data
  always_ff @(posedge pclk) begin
    if (rst) begin
      addr_q    <= '0;
      next_q    <= '0;
      act_dly_q <= '0;
    end else begin
      addr_q    <= addr_d;
      next_q    <= next_d;
      act_dly_q <= {act_dly_q[RD_LAT-1:0], active_raw};
    end
  end

  // Sync/origin delay line matched to the full data path
  always_ff @(posedge pclk) begin
    // NOTE: this is a short shift register, not a RAM, so every stage is reset to the blanking value; a partially flushed line must never reach the pins.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sync_dly_q[i] <= SYNC_BLANK;
    end else begin
      sync_dly_q[0] <= sync_raw;
      for (int i = 1; i < DEPTH; i++) sync_dly_q[i] <= sync_dly_q[i-1];
    end
  end

  // Buffer data is sampled and blanked in the pin register itself, which keeps
  // the data path at exactly RD_LAT+2 cycles from the counters
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= act_dly_q[RD_LAT] ? fb.buff_din : '0;
    end
  end

  assign fb.buff_addr = addr_q;
  assign fb.buff_rd   = act_dly_q[0];

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = sync_dly_q[DEPTH-1].hsync_n;
  assign vga_vs      = sync_dly_q[DEPTH-1].vsync_n;
  assign frame_start = sync_dly_q[DEPTH-1].origin;

endmodule

// File: tb/tb_vga_buffer_reader.sv
// Scoreboard bench for vga_buffer_reader: full-width lines, short frames.
module tb_vga_buffer_reader;
  import vga_buffer_reader_pkg::*;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYN  = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_ACT  = 8;
  localparam int V_FP   = 2;
  localparam int V_SYN  = 2;
  localparam int V_BP   = 3;
  localparam int V_TOT  = V_ACT + V_FP + V_SYN + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int LAT    = 3;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_start;

  vga_buffer_reader_if fb ();

  vga_buffer_reader #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
    .RD_LAT(1)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .fb          (fb),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  always #20 pclk = ~pclk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } pix_exp_t;

  typedef struct packed {
    logic        rd;
    logic        chk_addr;
    logic [18:0] addr;
  } rd_exp_t;

  pix_exp_t pix_q[$];
  rd_exp_t  rd_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc;
  logic        fff_mode;
  logic [11:0] pending;
  int          hs_falls, hs_fall_cyc, hs_rises;
  int          vs_falls, vs_fall_cyc, vs_rises;
  int          fs_cnt, fs_last, rd_cnt;
  logic        hs_prev, vs_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic pix_exp_t model_pix(input int c, input logic fff);
    int h, v;
    logic act;
    pix_exp_t e;
    h     = c % H_TOT;
    v     = (c / H_TOT) % V_TOT;
    act   = (h < H_ACT) && (v < V_ACT);
    e.rgb = act ? (fff ? 12'hFFF : 12'(v * H_ACT + h)) : 12'h000;
    e.hs  = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYN));
    e.vs  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYN));
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic rd_exp_t model_rd(input int c);
    int h, v;
    rd_exp_t e;
    h          = c % H_TOT;
    v          = (c / H_TOT) % V_TOT;
    e.rd       = (h < H_ACT) && (v < V_ACT);
    e.chk_addr = e.rd || (v >= V_ACT);
    e.addr     = e.rd ? 19'(v * H_ACT + h) : 19'd0;
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, 32'(fb.buff_addr), 32'd0);
    check({tag, "_rd"},   32'(fb.buff_rd), 32'd0);
    check({tag, "_rgb"},  32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_sync"}, 32'({vga_hs, vga_vs, frame_start}), 32'b110);
  endtask

  // Restart the reference timeline at cycle 0 with a blank pipeline
  task automatic restart();
    pix_exp_t blank;
    rd_exp_t  rd_blank;
    blank    = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    rd_blank = '{rd: 1'b0, chk_addr: 1'b1, addr: 19'd0};
    pix_q.delete();
    rd_q.delete();
    repeat (LAT) pix_q.push_back(blank);
    rd_q.push_back(rd_blank);
    cyc = 0;
    pending = 12'h000;
    hs_falls = 0; hs_rises = 0; hs_fall_cyc = -1;
    vs_falls = 0; vs_rises = 0; vs_fall_cyc = -1;
    fs_cnt = 0; fs_last = -1; rd_cnt = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  // One pixel clock, evaluated at the falling edge
  task automatic step();
    pix_exp_t pe;
    rd_exp_t  re;
    pix_q.push_back(model_pix(cyc, fff_mode));
    rd_q.push_back(model_rd(cyc));
    pe = pix_q.pop_front();
    re = rd_q.pop_front();
    check("rgb",  32'({vga_r, vga_g, vga_b}), 32'(pe.rgb));
    check("sync", 32'({vga_hs, vga_vs, frame_start}), 32'({pe.hs, pe.vs, pe.fs}));
    check("buff_rd", 32'(fb.buff_rd), 32'(re.rd));
    if (re.chk_addr) check("buff_addr", 32'(fb.buff_addr), 32'(re.addr));
    if (fff_mode && (!vga_hs || !vga_vs)) check("sync_blank_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);

    if (hs_prev && !vga_hs) begin
      if (hs_falls == 0) check("hs_fall_cycle", 32'(cyc), 32'(H_ACT + H_FP + LAT));
      if (hs_falls == 1) check("line_period", 32'(cyc - hs_fall_cyc), 32'(H_TOT));
      hs_falls++;
      hs_fall_cyc = cyc;
    end
    if (!hs_prev && vga_hs) begin
      if (hs_rises == 0) check("hs_rise_cycle", 32'(cyc), 32'(H_ACT + H_FP + H_SYN + LAT));
      hs_rises++;
    end
    if (vs_prev && !vga_vs) begin
      if (vs_falls == 0) check("vs_fall_cycle", 32'(cyc), 32'((V_ACT + V_FP) * H_TOT + LAT));
      vs_falls++;
      vs_fall_cyc = cyc;
    end
    if (!vs_prev && vga_vs) begin
      if (vs_rises == 0) check("vs_low_len", 32'(cyc - vs_fall_cyc), 32'(V_SYN * H_TOT));
      vs_rises++;
    end
    if (frame_start) begin
      if (fs_cnt == 0) check("first_frame_start", 32'(cyc), 32'(LAT));
      else             check("frame_period", 32'(cyc - fs_last), 32'(FRAME));
      fs_cnt++;
      fs_last = cyc;
    end

    rd_cnt += int'(fb.buff_rd);
    if (cyc > 0 && (cyc % FRAME) == 0) begin
      check("rd_per_frame", 32'(rd_cnt), 32'(H_ACT * V_ACT));
      rd_cnt = 0;
    end
    if (cyc == (V_ACT - 1) * H_TOT + H_ACT)
      check("last_addr", 32'(fb.buff_addr), 32'(H_ACT * V_ACT - 1));
    if (cyc > 1 && (cyc % FRAME) == 1)
      check("next_frame_addr", 32'(fb.buff_addr), 32'd0);

    hs_prev = vga_hs;
    vs_prev = vga_vs;

    // One-cycle-latency RAM whose word at address a is a[11:0]; junk when idle
    fb.buff_din = pending;
    pending = fff_mode ? 12'hFFF : (fb.buff_rd ? fb.buff_addr[11:0] : 12'hA5A);
    cyc++;
  endtask

  initial begin
    fff_mode    = 1'b0;
    fb.buff_din = 12'h000;
    rst         = 1'b1;
    cyc         = 0;
    repeat (3) @(negedge pclk);
    check_reset_state("reset");

    // Release: this falling edge lies in cycle 0
    restart();
    rst = 1'b0;
    step();
    while (cyc < 3 * FRAME + 3 * H_TOT + 300) begin
      @(negedge pclk);
      if (cyc == FRAME)     fff_mode = 1'b1;
      if (cyc == 2 * FRAME) fff_mode = 1'b0;
      step();
    end
    check("frame_start_count", 32'(fs_cnt), 32'd4);

    // Mid-frame reset held for two edges
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check_reset_state("midrst1");
    @(negedge pclk);
    check_reset_state("midrst2");
    restart();
    rst = 1'b0;
    step();
    while (cyc < 2 * H_TOT + 100) begin
      @(negedge pclk);
      step();
    end
    check("restart_hs_falls", 32'(hs_falls), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
